// File: rtl/branch_predictor_bht.sv
// Direct-mapped, tagged branch history table of 2-bit saturating counters with targets.
// Combinational fetch lookup, execute-side training, and saturating bring-up counters.
module branch_predictor_bht #(
    parameter int unsigned N     = 32,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     f_pc,
    output logic             f_pred_taken,
    output logic [N-1:0]     f_pred_target,
    input  logic             u_valid,
    input  logic [N-1:0]     u_pc,
    input  logic             u_is_jump,
    input  logic             u_taken,
    input  logic [N-1:0]     u_target,
    input  logic             u_mispred,
    output logic [CNT_W-1:0] n_resolved,
    output logic [CNT_W-1:0] n_mispred
);
    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = N - IDX_W - 2;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         cnt_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [N-1:0]       tgt_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [1:0]       u_cnt_cur;
    logic [1:0]       u_cnt_nxt;
    logic             u_tgt_we;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^{f_pc[1:0], u_pc[1:0]};

    // Fetch lookup sees the registered table, so same-cycle updates are read-before-write.
    assign f_idx         = f_pc[IDX_W+1:2];
    assign f_tag         = f_pc[N-1:IDX_W+2];
    assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_pred_taken  = f_hit && cnt_q[f_idx][1];
    assign f_pred_target = f_pred_taken ? tgt_q[f_idx] : f_pc + N'(4);

    assign u_idx     = u_pc[IDX_W+1:2];
    assign u_tag     = u_pc[N-1:IDX_W+2];
    assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_cnt_cur = cnt_q[u_idx];
    assign u_tgt_we  = !u_hit || u_is_jump || u_taken;

    // Next counter value for the entry being trained.
    always_comb begin
        u_cnt_nxt = u_cnt_cur;
        if (!u_hit) begin
            u_cnt_nxt = u_is_jump ? ST : (u_taken ? WT : WNT);
        end else if (u_is_jump) begin
            u_cnt_nxt = ST;
        end else if (u_taken) begin
            if (u_cnt_cur != ST) u_cnt_nxt = u_cnt_cur + 2'(1);
        end else begin
            if (u_cnt_cur != SNT) u_cnt_nxt = u_cnt_cur - 2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
        end else if (u_valid) begin
            valid_q[u_idx] <= 1'b1;
            cnt_q[u_idx]   <= u_cnt_nxt;
        end
    end

    // Tag and target storage is never cleared; valid bits guard it.
    always_ff @(posedge clk) begin
        if (!reset && u_valid) begin
            if (!u_hit)   tag_q[u_idx] <= u_tag;
            if (u_tgt_we) tgt_q[u_idx] <= u_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_resolved <= '0;
            n_mispred  <= '0;
        end else if (u_valid) begin
            if (n_resolved != {CNT_W{1'b1}}) n_resolved <= n_resolved + CNT_W'(1);
            if (u_mispred && (n_mispred != {CNT_W{1'b1}})) n_mispred <= n_mispred + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht; 4-bit perf counters so saturation is reachable.
module tb_branch_predictor_bht;
    localparam int unsigned N     = 32;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     f_pc;
    logic             f_pred_taken;
    logic [N-1:0]     f_pred_target;
    logic             u_valid;
    logic [N-1:0]     u_pc;
    logic             u_is_jump;
    logic             u_taken;
    logic [N-1:0]     u_target;
    logic             u_mispred;
    logic [CNT_W-1:0] n_resolved;
    logic [CNT_W-1:0] n_mispred;

    int errors = 0;
    int checks = 0;

    branch_predictor_bht #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .f_pc(f_pc),
        .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
        .u_valid(u_valid), .u_pc(u_pc), .u_is_jump(u_is_jump), .u_taken(u_taken),
        .u_target(u_target), .u_mispred(u_mispred),
        .n_resolved(n_resolved), .n_mispred(n_mispred)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        u_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One resolved control transfer, applied at the next rising edge.
    task automatic upd(input logic [31:0] pc, input logic jump, input logic taken,
                       input logic [31:0] tgt, input logic mis);
        @(negedge clk);
        u_valid = 1'b1; u_pc = pc; u_is_jump = jump; u_taken = taken;
        u_target = tgt; u_mispred = mis;
        @(negedge clk);
        u_valid = 1'b0; u_mispred = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_tgt);
        f_pc = pc;
        #1;
        check({tag, ".taken"}, 32'(f_pred_taken), 32'(exp_taken));
        check({tag, ".target"}, f_pred_target, exp_tgt);
    endtask

    initial begin
        reset = 1'b1; f_pc = '0; u_valid = 1'b0; u_pc = '0; u_is_jump = 1'b0;
        u_taken = 1'b0; u_target = '0; u_mispred = 1'b0;
        do_reset();

        // Reset state
        look("rst", 32'h100, 1'b0, 32'h104);
        check("rst.n_resolved", 32'(n_resolved), 32'd0);
        check("rst.n_mispred", 32'(n_mispred), 32'd0);

        // Allocate taken -> WT, then not-taken -> WNT (target kept, but not predicted)
        upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        look("alloc_wt", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 1'b0, 32'h999, 1'b0);
        look("dec_wnt", 32'h100, 1'b0, 32'h104);

        // Saturation both ways: WNT +4 -> ST, -1 -> WT, -3 -> SNT, -1 stays SNT
        for (int i = 0; i < 4; i++) upd(32'h100, 1'b0, 1'b1, 32'h40, 1'b0);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look("st_to_wt", 32'h100, 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look("to_snt", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        upd(32'h100, 1'b0, 1'b1, 32'h44, 1'b0);
        look("snt_hold", 32'h100, 1'b0, 32'h104);

        // Alias on idx 0 with a new tag: replace, then jump forces ST
        upd(32'h100, 1'b0, 1'b1, 32'h48, 1'b0);
        look("pre_alias", 32'h100, 1'b1, 32'h48);
        upd(32'h200, 1'b0, 1'b0, 32'h300, 1'b0);
        look("alias_miss", 32'h100, 1'b0, 32'h104);
        look("alias_wnt", 32'h200, 1'b0, 32'h204);
        upd(32'h200, 1'b1, 1'b1, 32'h500, 1'b0);
        look("alias_jump", 32'h200, 1'b1, 32'h500);
        upd(32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        look("jump_st_dec", 32'h200, 1'b1, 32'h500);

        // Mid-run reset discards training
        do_reset();
        look("rst_discard", 32'h200, 1'b0, 32'h204);

        // Read-before-write on a same-cycle lookup and update
        @(negedge clk);
        f_pc = 32'h200;
        u_valid = 1'b1; u_pc = 32'h200; u_is_jump = 1'b0; u_taken = 1'b1;
        u_target = 32'h600; u_mispred = 1'b0;
        #1;
        check("rbw_same.taken", 32'(f_pred_taken), 32'd0);
        check("rbw_same.target", f_pred_target, 32'h204);
        @(negedge clk);
        u_valid = 1'b0;
        look("rbw_next", 32'h200, 1'b1, 32'h600);
        look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Performance counters: u_mispred ignored without u_valid
        do_reset();
        for (int i = 0; i < 10; i++)
            upd(32'h1000 + 32'(4 * i), 1'b0, 1'b0, 32'h0, (i % 4) == 1);
        @(negedge clk); u_mispred = 1'b1;
        @(negedge clk); @(negedge clk); u_mispred = 1'b0;
        check("cnt.resolved", 32'(n_resolved), 32'd10);
        check("cnt.mispred", 32'(n_mispred), 32'd3);
        for (int i = 0; i < 6; i++) upd(32'h2000, 1'b0, 1'b1, 32'h0, 1'b1);
        check("cnt.resolved_sat", 32'(n_resolved), 32'hF);
        check("cnt.mispred_9", 32'(n_mispred), 32'd9);
        for (int i = 0; i < 8; i++) upd(32'h2000, 1'b0, 1'b1, 32'h0, 1'b1);
        check("cnt.resolved_hold", 32'(n_resolved), 32'hF);
        check("cnt.mispred_sat", 32'(n_mispred), 32'hF);

        // Update coincident with reset is discarded
        @(negedge clk);
        reset = 1'b1;
        u_valid = 1'b1; u_pc = 32'h300; u_is_jump = 1'b1; u_taken = 1'b1;
        u_target = 32'h700; u_mispred = 1'b1;
        @(negedge clk);
        u_valid = 1'b0; u_mispred = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        look("rst_upd", 32'h300, 1'b0, 32'h304);
        check("rst_upd.n_resolved", 32'(n_resolved), 32'd0);
        check("rst_upd.n_mispred", 32'(n_mispred), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
